// File: rtl/autocorr_frame_seq_pkg.sv
// Shared definitions for the autocorrelation frame sequencer: state encoding,
// scratch-memory base of the coefficient array and the core watchdog limit.
package autocorr_frame_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        READ    = 3'd4,
        PRESENT = 3'd5
    } seq_state_t;

    localparam logic [10:0] AUTOCORR_R = 11'h400;
    localparam int unsigned WD_LIMIT   = 4096;

    function automatic logic [31:0] sext16(input logic [15:0] s);
        return {{16{s[15]}}, s};
    endfunction

endpackage

// File: rtl/autocorr_frame_seq_if.sv
// Handshake and memory-port bundle between the frame sequencer (master) and
// its surroundings: sample source, x memory, autocorr core, scratch reads, coef sink.
interface autocorr_frame_seq_if;
    logic        enable;
    logic [15:0] sampleIn;
    logic        sampleValid;
    logic        sampleReady;
    logic [7:0]  xMemAddr;
    logic [31:0] xMemOut;
    logic        xMemEn;
    logic        autocorrMuxSel;
    logic        coreStart;
    logic        coreDone;
    logic [10:0] readAddr;
    logic [31:0] memIn;
    logic [31:0] coefOut;
    logic [3:0]  coefIdx;
    logic        coefValid;
    logic        coefReady;
    logic        frameDone;
    logic        busy;
    logic        timeoutErr;

    modport master (
        input  enable, sampleIn, sampleValid, coreDone, memIn, coefReady,
        output sampleReady, xMemAddr, xMemOut, xMemEn, autocorrMuxSel, coreStart,
               readAddr, coefOut, coefIdx, coefValid, frameDone, busy, timeoutErr
    );

    modport slave (
        output enable, sampleIn, sampleValid, coreDone, memIn, coefReady,
        input  sampleReady, xMemAddr, xMemOut, xMemEn, autocorrMuxSel, coreStart,
               readAddr, coefOut, coefIdx, coefValid, frameDone, busy, timeoutErr
    );
endinterface

// File: rtl/autocorr_frame_seq.sv
// Frame sequencer: loads a frame into x memory, kicks the autocorr core, then streams
// the coefficients back out. Define WATCHDOG_EN to abort a frame when the core hangs.
//
// state   | meaning
// IDLE    | no frame in progress, sequencer owns memory
// LOAD    | accepting samples and writing them to x memory
// START   | one-cycle coreStart pulse, core owns memory
// WAIT    | waiting for coreDone
// READ    | scratch read of r[coefIdx] in flight
// PRESENT | coefficient offered on coefOut until accepted
module autocorr_frame_seq
    import autocorr_frame_seq_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 240,
    parameter int unsigned NUM_COEF  = 11,
    parameter logic [10:0] R_BASE    = AUTOCORR_R,
    parameter int unsigned READ_LAT  = 2
) (
    input logic               clk,
    input logic               reset,
    autocorr_frame_seq_if.master bus
);

    seq_state_t  state_q, state_d;
    logic [7:0]  smp_cnt_q, smp_cnt_d;
    logic [3:0]  coef_idx_q, coef_idx_d;
    logic [7:0]  lat_cnt_q, lat_cnt_d;
    logic [31:0] coef_out_q, coef_out_d;
    logic [10:0] read_addr_q, read_addr_d;
    logic        frame_done_q, frame_done_d;
    logic        sample_ready_q, sample_ready_d;
    logic        core_start_q, core_start_d;
    logic        mux_sel_q, mux_sel_d;
    logic        coef_valid_q, coef_valid_d;
    logic        busy_q, busy_d;
    logic        sample_fire;
`ifdef WATCHDOG_EN
    logic [11:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;
`endif

    assign sample_fire = sample_ready_q & bus.sampleValid;

    always_comb begin
        state_d      = state_q;
        smp_cnt_d    = smp_cnt_q;
        coef_idx_d   = coef_idx_q;
        lat_cnt_d    = lat_cnt_q;
        coef_out_d   = coef_out_q;
        read_addr_d  = read_addr_q;
        frame_done_d = 1'b0;
`ifdef WATCHDOG_EN
        wd_cnt_d     = wd_cnt_q;
        timeout_d    = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d   = LOAD;
                    smp_cnt_d = '0;
                end
            end
            LOAD: begin
                if (sample_fire) begin
                    if (smp_cnt_q == 8'(FRAME_LEN - 1)) begin
                        state_d   = START;
                        smp_cnt_d = '0;
                    end else begin
                        smp_cnt_d = smp_cnt_q + 8'd1;
                    end
                end
            end
            START: begin
                state_d = WAIT;
`ifdef WATCHDOG_EN
                wd_cnt_d = 12'(WD_LIMIT - 1);
`endif
            end
            WAIT: begin
                if (bus.coreDone) begin
                    state_d     = READ;
                    read_addr_d = R_BASE + 11'(coef_idx_q);
                    lat_cnt_d   = 8'(READ_LAT - 1);
`ifdef WATCHDOG_EN
                end else if (wd_cnt_q == '0) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q - 12'd1;
`endif
                end
            end
            READ: begin
                // readAddr has been stable since READ entry; data is valid on the last cycle
                if (lat_cnt_q == '0) begin
                    coef_out_d = bus.memIn;
                    state_d    = PRESENT;
                end else begin
                    lat_cnt_d = lat_cnt_q - 8'd1;
                end
            end
            PRESENT: begin
                if (bus.coefReady) begin
                    if (coef_idx_q == 4'(NUM_COEF - 1)) begin
                        coef_idx_d   = '0;
                        frame_done_d = 1'b1;
                        smp_cnt_d    = '0;
                        state_d      = bus.enable ? LOAD : IDLE;
                    end else begin
                        coef_idx_d  = coef_idx_q + 4'd1;
                        read_addr_d = R_BASE + 11'(coef_idx_q + 4'd1);
                        lat_cnt_d   = 8'(READ_LAT - 1);
                        state_d     = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        sample_ready_d = (state_d == LOAD);
        core_start_d   = (state_d == START);
        mux_sel_d      = !((state_d == START) || (state_d == WAIT));
        coef_valid_d   = (state_d == PRESENT);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            smp_cnt_q      <= '0;
            coef_idx_q     <= '0;
            lat_cnt_q      <= '0;
            coef_out_q     <= '0;
            read_addr_q    <= '0;
            frame_done_q   <= 1'b0;
            sample_ready_q <= 1'b0;
            core_start_q   <= 1'b0;
            mux_sel_q      <= 1'b1;
            coef_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
`ifdef WATCHDOG_EN
            wd_cnt_q       <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            smp_cnt_q      <= smp_cnt_d;
            coef_idx_q     <= coef_idx_d;
            lat_cnt_q      <= lat_cnt_d;
            coef_out_q     <= coef_out_d;
            read_addr_q    <= read_addr_d;
            frame_done_q   <= frame_done_d;
            sample_ready_q <= sample_ready_d;
            core_start_q   <= core_start_d;
            mux_sel_q      <= mux_sel_d;
            coef_valid_q   <= coef_valid_d;
            busy_q         <= busy_d;
`ifdef WATCHDOG_EN
            wd_cnt_q       <= wd_cnt_d;
            timeout_q      <= timeout_d;
`endif
        end
    end

    // x-memory write happens in the handshake cycle itself
    assign bus.xMemEn         = sample_fire;
    assign bus.xMemAddr       = smp_cnt_q;
    assign bus.xMemOut        = sample_fire ? sext16(bus.sampleIn) : 32'd0;
    assign bus.sampleReady    = sample_ready_q;
    assign bus.coreStart      = core_start_q;
    assign bus.autocorrMuxSel = mux_sel_q;
    assign bus.readAddr       = read_addr_q;
    assign bus.coefOut        = coef_out_q;
    assign bus.coefIdx        = coef_idx_q;
    assign bus.coefValid      = coef_valid_q;
    assign bus.frameDone      = frame_done_q;
    assign bus.busy           = busy_q;
`ifdef WATCHDOG_EN
    assign bus.timeoutErr     = timeout_q;
`else
    assign bus.timeoutErr     = 1'b0;
`endif

endmodule

// File: tb/tb_autocorr_frame_seq.sv
// Bench for autocorr_frame_seq: directed frames against a transaction-level model of
// sample writes, core ownership, coefficient stream and frame completion.
module tb_autocorr_frame_seq;
    import autocorr_frame_seq_pkg::*;

    localparam int          FRAME_LEN = 240;
    localparam int          NUM_COEF  = 11;
    localparam int          READ_LAT  = 2;
    localparam logic [10:0] R_BASE    = AUTOCORR_R;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    autocorr_frame_seq_if bus();

    autocorr_frame_seq #(
        .FRAME_LEN(FRAME_LEN),
        .NUM_COEF (NUM_COEF),
        .R_BASE   (R_BASE),
        .READ_LAT (READ_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // scratch memory: r[i] = 0x1000+i, readable READ_LAT cycles after the address settles
    logic [10:0] addr_d1 = '0;
    always @(posedge clk) addr_d1 <= bus.readAddr;

    function automatic logic [31:0] mem_model(input logic [10:0] a);
        if (a >= R_BASE && a < R_BASE + 11'(NUM_COEF))
            return 32'h1000 + 32'(a - R_BASE);
        return 32'hDEAD0000 | 32'(a);
    endfunction

    always_comb bus.memIn = mem_model(addr_d1);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    logic [15:0] exp_samples [FRAME_LEN];

    // ---------------- model / compare process ----------------
    int          wr_cnt = 0, last_wr_cyc = 0, start_cyc = 0, done_cyc = 0;
    int          beat = 0, frames = 0;
    bit          owned = 0, first_pending = 0, hold_valid = 0;
    logic [31:0] hold_out;
    logic [3:0]  hold_idx;
    logic [15:0] s_tmp;

    always @(negedge clk) begin
        if (reset) begin
            wr_cnt = 0; beat = 0; owned = 0; first_pending = 0; hold_valid = 0;
        end else begin
            if (bus.xMemEn) begin
                if (wr_cnt < FRAME_LEN) begin
                    s_tmp = exp_samples[wr_cnt];
                    check("xmem_addr", 32'(bus.xMemAddr), 32'(wr_cnt));
                    check("xmem_data", bus.xMemOut, {{16{s_tmp[15]}}, s_tmp});
                end else begin
                    check("xmem_extra_write", 32'(wr_cnt), 32'(FRAME_LEN - 1));
                end
                wr_cnt++;
                last_wr_cyc = cyc;
            end
            if (bus.coreStart) begin
                check("corestart_latency", 32'(cyc), 32'(last_wr_cyc + 1));
                check("corestart_count", 32'(wr_cnt), 32'(FRAME_LEN));
                wr_cnt = 0; owned = 1; start_cyc = cyc;
            end
            check("mux_sel", 32'(bus.autocorrMuxSel), 32'(!owned));
            if (owned || bus.coefValid || bus.sampleReady)
                check("busy_active", 32'(bus.busy), 32'd1);
            if (owned && bus.coreDone && cyc != start_cyc) begin
                owned = 0; done_cyc = cyc; first_pending = 1;
            end
`ifdef WATCHDOG_EN
            if (owned && (cyc - start_cyc) == int'(WD_LIMIT)) owned = 0;
`endif
            if (hold_valid)
                check("coef_hold", {bus.coefValid, bus.coefIdx, bus.coefOut[26:0]},
                      {1'b1, hold_idx, hold_out[26:0]});
            hold_valid = 0;
            if (bus.coefValid) begin
                if (first_pending) begin
                    check("first_coef_latency", 32'(cyc), 32'(done_cyc + READ_LAT + 1));
                    first_pending = 0;
                end
                if (bus.coefReady) begin
                    check("coef_idx", 32'(bus.coefIdx), 32'(beat));
                    check("coef_out", bus.coefOut, 32'h1000 + 32'(beat));
                    beat++;
                end else begin
                    hold_valid = 1; hold_out = bus.coefOut; hold_idx = bus.coefIdx;
                end
            end
            if (bus.frameDone) begin
                check("framedone_beats", 32'(beat), 32'(NUM_COEF));
                beat = 0;
                frames++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic sig_sel(input int which);
        case (which)
            0:       return bus.coreStart;
            1:       return bus.frameDone;
            default: return bus.coefValid;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (!sig_sel(which) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sig_sel(which)), 32'd1);
    endtask

    task automatic send_frame(input bit gaps, input int chk_idx, input logic [31:0] chk_val);
        int   idx = 0;
        int   guard = 0;
        logic acc;
        while (idx < FRAME_LEN && guard < 4 * FRAME_LEN) begin
            bus.sampleIn    = exp_samples[idx];
            bus.sampleValid = !(gaps && (guard % 7 == 3));
            @(negedge clk);
            acc = bus.sampleValid && bus.sampleReady;
            if (acc && idx == chk_idx) begin
                check("xmem_addr_literal", 32'(bus.xMemAddr), 32'(chk_idx));
                check("xmem_data_literal", bus.xMemOut, chk_val);
            end
            @(posedge clk); #1;
            if (acc) idx++;
            guard++;
        end
        bus.sampleValid = 1'b0;
        check("load_complete", 32'(idx), 32'(FRAME_LEN));
    endtask

    task automatic pulse_core_done(input int delay);
        repeat (delay) @(posedge clk);
        #1 bus.coreDone = 1'b1;
        @(posedge clk);
        #1 bus.coreDone = 1'b0;
    endtask

    task automatic consume(input bit stall);
        int n;
        for (int b = 0; b < NUM_COEF; b++) begin
            n = 0;
            @(negedge clk);
            while (!bus.coefValid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!bus.coefValid) begin
                check("coef_wait", 32'd0, 32'd1);
                return;
            end
            if (stall && b == 3) begin
                repeat (10) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    check("stall_out_literal", bus.coefOut, 32'h00001003);
                    check("stall_idx_literal", {bus.coefValid, bus.coefIdx}, {1'b1, 4'd3});
                end
            end
            @(posedge clk); #1 bus.coefReady = 1'b1;
            @(posedge clk); #1 bus.coefReady = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {bus.busy, bus.sampleReady, bus.xMemEn, bus.coreStart,
                               bus.coefValid, bus.frameDone, bus.timeoutErr, bus.autocorrMuxSel},
              32'b0000_0001);
        check({tag, "_coefout"}, bus.coefOut, 32'd0);
        check({tag, "_coefidx"}, 32'(bus.coefIdx), 32'd0);
        check({tag, "_readaddr"}, 32'(bus.readAddr), 32'd0);
        check({tag, "_xmem"}, {bus.xMemAddr, 24'd0} | (bus.xMemOut & 32'h00FF_FFFF), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.sampleIn    = '0;
        bus.sampleValid = 1'b0;
        bus.coreDone    = 1'b0;
        bus.coefReady   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        check("idle_no_enable", {bus.busy, bus.sampleReady, bus.autocorrMuxSel}, 32'b001);

        // frame 1: ramp 0x0001..0x00F0, sampleValid held high, coefReady always high
        for (int k = 0; k < FRAME_LEN; k++) exp_samples[k] = 16'(k + 1);
        @(posedge clk); #1;
        bus.enable    = 1'b1;
        bus.coefReady = 1'b1;
        send_frame(1'b0, 239, 32'h000000F0);
        wait_for(0, 4, "corestart_f1");
        pulse_core_done(50);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.coefValid && n < 20);
        check("first_coef_delay_literal", 32'(n), 32'd3);
        check("first_coef_literal", {bus.coefOut[27:0], bus.coefIdx}, {28'h0001000, 4'd0});
        wait_for(1, 200, "framedone_f1");
        check("f1_reload_ready", 32'(bus.sampleReady), 32'd1);

        // frame 2: signed samples, valid gaps, stray coreDone in LOAD, stall at index 3
        for (int k = 0; k < FRAME_LEN; k++) exp_samples[k] = 16'(k * 305 + 165);
        exp_samples[5] = 16'h8000;
        exp_samples[6] = 16'hFFFF;
        exp_samples[7] = 16'h7FFF;
        bus.coefReady = 1'b0;
        @(posedge clk); #1;
        fork
            send_frame(1'b1, 5, 32'hFFFF8000);
            pulse_core_done(30);
        join
        bus.enable = 1'b0;
        wait_for(0, 4, "corestart_f2");
        pulse_core_done(20);
        consume(1'b1);
        wait_for(1, 10, "framedone_f2");
        repeat (2) @(negedge clk);
        check("idle_after_f2", {bus.busy, bus.sampleReady, bus.autocorrMuxSel}, 32'b001);

        // frame 3: reset while waiting for the core
        for (int k = 0; k < FRAME_LEN; k++) exp_samples[k] = 16'(k + 1);
        @(posedge clk); #1 bus.enable = 1'b1;
        send_frame(1'b0, -1, 32'd0);
        wait_for(0, 4, "corestart_f3");
        repeat (5) @(posedge clk);
        #1;
        reset      = 1'b1;
        bus.enable = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("wait_reset");
        repeat (3) begin
            @(negedge clk);
            check("no_framedone_after_reset", {bus.frameDone, bus.busy}, 32'b00);
        end

        // frame 4: core never answers
        @(posedge clk); #1 bus.enable = 1'b1;
        send_frame(1'b0, -1, 32'd0);
        wait_for(0, 4, "corestart_f4");
        bus.enable = 1'b0;
        repeat (4100) @(negedge clk);
`ifdef WATCHDOG_EN
        check("watchdog_state", {bus.timeoutErr, bus.busy, bus.autocorrMuxSel}, 32'b101);
`else
        check("no_watchdog_state", {bus.timeoutErr, bus.busy, bus.autocorrMuxSel}, 32'b010);
`endif
        check("frames_completed", 32'(frames), 32'd2);

        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("final_timeout_clear", 32'(bus.timeoutErr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/autocorr_frame_seq.md
AUTOCORR_FRAME_SEQ -- requirements
Module: autocorr_frame_seq

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 240, samples per frame written to x memory.
REQ-002 SHALL have parameter NUM_COEF, default 11, autocorrelation coefficients read back per frame.
REQ-003 SHALL have parameter R_BASE, default AUTOCORR_R from the shared package, 11-bit base address of r[] in scratch memory.
REQ-004 SHALL have parameter READ_LAT, default 2, cycles from readAddr stable to memIn valid.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have ports: clk  in  1  clock; reset  in  1  sync active-high reset.
REQ-007 SHALL have ports: enable  in  1  permit new frame; sampleIn  in  16  input sample; sampleValid  in  1; sampleReady  out  1.
REQ-008 SHALL have ports: xMemAddr  out  8; xMemOut  out  32  sign-extended sample; xMemEn  out  1  x-memory write strobe.
REQ-009 SHALL have ports: autocorrMuxSel  out  1  (1 = sequencer owns memory, 0 = core); coreStart  out  1; coreDone  in  1.
REQ-010 SHALL have ports: readAddr  out  11  (to testReadRequested); memIn  in  32  memory read data.
REQ-011 SHALL have ports: coefOut  out  32; coefIdx  out  4; coefValid  out  1; coefReady  in  1; frameDone  out  1  one-cycle pulse; busy  out  1; timeoutErr  out  1.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, START, WAIT, READ, PRESENT.
REQ-013 IDLE: busy=0, autocorrMuxSel=1; enable=1 -> LOAD with sample counter 0.
REQ-014 LOAD: sampleReady=1; each sampleValid&sampleReady cycle SHALL drive xMemEn=1, xMemAddr=counter, xMemOut={{16{s[15]}},s} in the same cycle, then increment the counter.
REQ-015 LOAD: acceptance of sample FRAME_LEN-1 -> START; sampleValid with sampleReady=0 SHALL be ignored.
REQ-016 START: one cycle, coreStart=1, autocorrMuxSel=0 -> WAIT.
REQ-017 WAIT: autocorrMuxSel=0; coreDone=1 -> READ, autocorrMuxSel=1 from the next cycle; coreDone in any other state SHALL be ignored.
REQ-018 READ: readAddr=R_BASE+coefIdx held stable for READ_LAT cycles, then memIn captured into coefOut -> PRESENT.
REQ-019 PRESENT: coefValid=1 with coefOut/coefIdx stable until coefValid&coefReady; then coefIdx+1 -> READ, or, after index NUM_COEF-1, frameDone=1 for one cycle -> LOAD if enable=1, else IDLE.
REQ-020 Deassertion of enable mid-frame SHALL NOT abort the frame; it only prevents the next frame from starting.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Latency: coreStart SHALL assert exactly 1 cycle after the last sample handshake; the first coefValid SHALL assert READ_LAT+1 cycles after coreDone.

Reset
REQ-023 reset SHALL force IDLE, counters 0, autocorrMuxSel=1, and every other output 0 (coefOut=0, coefIdx=0).
REQ-024 reset mid-operation SHALL abandon the frame without a frameDone pulse; timeoutErr SHALL clear.

Configuration
REQ-025 With WATCHDOG_EN defined: a counter SHALL run in WAIT; if coreDone is absent for 4096 cycles, timeoutErr SHALL set (sticky until reset) and the FSM SHALL go to IDLE with autocorrMuxSel=1.
REQ-026 Without WATCHDOG_EN: WAIT SHALL wait indefinitely and timeoutErr SHALL be tied to 0.

Structure
REQ-027 The state encoding, AUTOCORR_R, and the watchdog limit 4096 SHALL live in the shared package (paramList).
REQ-028 The design SHALL be a single module with no sub-modules; the read-latency delay is an internal counter.

Verification
REQ-029 Reset then 240 samples 0x0001..0x00F0 with sampleValid held high -> 240 xMemEn writes at addresses 0..239, coreStart 1 cycle after the last.
REQ-030 Sample 0x8000 at index 5 -> xMemOut=0xFFFF8000 at xMemAddr=5.
REQ-031 coreDone 50 cycles after coreStart with memIn model r[i]=0x1000+i -> 11 coefValid beats with coefOut=0x1000..0x100A, coefIdx 0..10, then one frameDone pulse.
REQ-032 coefReady held low 10 cycles on index 3 -> coefOut=0x1003 held stable for those cycles with no index skipped; coreDone pulsed during LOAD -> ignored.
REQ-033 reset asserted in WAIT -> next cycle all outputs at reset values, autocorrMuxSel=1, no frameDone.
REQ-034 WATCHDOG_EN defined, coreDone never asserted -> timeoutErr=1 after 4096 WAIT cycles, state IDLE; without the macro -> busy stays 1 and timeoutErr=0.
